// File: rtl/mic_peak_tracker.sv
// Microphone front end: display-scaled sample, windowed peak, volume index
// and a sustained-silence flag, all held while freeze is high.
module mic_peak_tracker #(
  parameter int IN_W          = 12,
  parameter int OUT_W         = 10,
  parameter int WINDOW        = 4000,
  parameter int QUIET_TH      = 200,
  parameter int QUIET_WINDOWS = 50
) (
  input  logic             clk_sample,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic [IN_W-1:0]  mic_in,
  output logic [OUT_W-1:0] wave_sample,
  output logic [OUT_W-1:0] sample_max,
  output logic             max_valid,
  output logic [3:0]       volume_level,
  output logic             quiet
);

  localparam int CNT_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int QCNT_W    = $clog2(QUIET_WINDOWS + 1);
  localparam int VOL_BASE  = 1 << (OUT_W - 1);
  localparam int VOL_STEP  = 1 << (OUT_W - 5);
  localparam int VOL_STEPS = 15;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  state_t eff_state;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  run_max_q, run_max_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic [OUT_W-1:0]  wave_q, wave_d;
  logic [OUT_W-1:0]  smax_q, smax_d;
  logic              mvalid_q, mvalid_d;
  logic [3:0]        vol_q, vol_d;
  logic              quiet_q, quiet_d;

  logic [OUT_W-1:0]  s;
  logic [OUT_W-1:0]  peak_new;
  logic              win_end;
  logic              advance;
  logic              close_window;
  logic [VOL_STEPS-1:0] vol_hit;
  logic [3:0]        vol_new;
  logic              quiet_win;
  logic [QCNT_W-1:0] qcnt_next;

  assign s        = mic_in[IN_W-1 -: OUT_W];
  assign peak_new = (s > run_max_q) ? s : run_max_q;
  assign win_end  = (cnt_q == CNT_W'(WINDOW - 1));

  generate
    if (IN_W > OUT_W) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^mic_in[IN_W-OUT_W-1:0];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIME;
      ret_q   <= PRIME;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // FROZEN remembers where it came from so a PRIME window survives a freeze.
  assign eff_state = (state_q == FROZEN) ? ret_q : state_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (freeze) begin
      state_d = FROZEN;
      if (state_q != FROZEN) begin
        ret_d = state_q;
      end
    end else if (eff_state == PRIME && win_end) begin
      state_d = RUN;
    end else begin
      state_d = eff_state;
    end
  end

  always_comb begin
    advance = 1'b0;
    case (state_q)
      PRIME, RUN: advance = !freeze;
      FROZEN:     advance = !freeze;
      default:    advance = 1'b0;
    endcase
    close_window = advance && win_end;
  end

  // -------------------------------------------------------------------------
  // Volume: thermometer of thresholds VOL_BASE + k*VOL_STEP, k = 1..15
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 1; gi <= VOL_STEPS; gi++) begin : g_vol
      assign vol_hit[gi-1] = (peak_new >= OUT_W'(VOL_BASE + VOL_STEP * gi));
    end
  endgenerate

  always_comb begin
    vol_new = 4'd0;
    for (int i = 0; i < VOL_STEPS; i++) begin
      if (vol_hit[i]) begin
        vol_new = 4'(i + 1);
      end
    end
  end

  assign quiet_win = (peak_new < OUT_W'(QUIET_TH));

  always_comb begin
    qcnt_next = '0;
    if (quiet_win) begin
      qcnt_next = (qcnt_q == QCNT_W'(QUIET_WINDOWS)) ? qcnt_q : qcnt_q + QCNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    qcnt_d    = qcnt_q;
    wave_d    = wave_q;
    smax_d    = smax_q;
    mvalid_d  = 1'b0;
    vol_d     = vol_q;
    quiet_d   = quiet_q;
    if (advance) begin
      wave_d = s;
      if (close_window) begin
        // The closing sample belongs to this window, never the next one.
        smax_d    = peak_new;
        mvalid_d  = 1'b1;
        run_max_d = '0;
        cnt_d     = '0;
        vol_d     = vol_new;
        qcnt_d    = qcnt_next;
        quiet_d   = (qcnt_next == QCNT_W'(QUIET_WINDOWS));
      end else begin
        run_max_d = peak_new;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      qcnt_q    <= '0;
      wave_q    <= '0;
      smax_q    <= '0;
      mvalid_q  <= 1'b0;
      vol_q     <= 4'd0;
      quiet_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      qcnt_q    <= qcnt_d;
      wave_q    <= wave_d;
      smax_q    <= smax_d;
      mvalid_q  <= mvalid_d;
      vol_q     <= vol_d;
      quiet_q   <= quiet_d;
    end
  end

  assign wave_sample  = wave_q;
  assign sample_max   = smax_q;
  assign max_valid    = mvalid_q;
  assign volume_level = vol_q;
  assign quiet        = quiet_q;

endmodule

// File: tb/tb_mic_peak_tracker.sv
// Directed bench for mic_peak_tracker, run with a shortened window so the
// fifty-window silence detection fits in a short simulation.
module tb_mic_peak_tracker;

  localparam int IN_W  = 12;
  localparam int OUT_W = 10;
  localparam int W     = 400;
  localparam int QW    = 50;

  logic             clk_sample;
  logic             rst_n;
  logic             freeze;
  logic [IN_W-1:0]  mic_in;
  logic [OUT_W-1:0] wave_sample;
  logic [OUT_W-1:0] sample_max;
  logic             max_valid;
  logic [3:0]       volume_level;
  logic             quiet;

  int total = 0;
  int bad   = 0;

  mic_peak_tracker #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WINDOW(W), .QUIET_TH(200), .QUIET_WINDOWS(QW)
  ) dut (
    .clk_sample  (clk_sample),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .mic_in      (mic_in),
    .wave_sample (wave_sample),
    .sample_max  (sample_max),
    .max_valid   (max_valid),
    .volume_level(volume_level),
    .quiet       (quiet)
  );

  initial clk_sample = 1'b0;
  always #5 clk_sample = ~clk_sample;

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  // Ticks until max_valid is seen; n = ticks taken, or -1 on timeout.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (max_valid === 1'b1) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    freeze = 1'b0;
    mic_in = 12'd2048;
    rst_n  = 1'b0;
    #12;
    total++; if (wave_sample !== 10'd0) begin bad++; $display("FAIL reset_wave got=%0d exp=0", wave_sample); end
    total++; if (sample_max !== 10'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", sample_max); end
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", max_valid); end
    total++; if (volume_level !== 4'd0) begin bad++; $display("FAIL reset_vol got=%0d exp=0", volume_level); end
    total++; if (quiet !== 1'b0) begin bad++; $display("FAIL reset_quiet got=%0b exp=0", quiet); end
    @(negedge clk_sample);
    rst_n = 1'b1;
    tick();
    total++; if (wave_sample !== 10'd512) begin bad++; $display("FAIL first_wave got=%0d exp=512", wave_sample); end
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early got=%0b exp=0", max_valid); end
    wait_valid(2 * W, n);
    total++; if (n !== W - 1) begin bad++; $display("FAIL prime_latency got=%0d exp=%0d", n, W - 1); end
    total++; if (sample_max !== 10'd512) begin bad++; $display("FAIL prime_max got=%0d exp=512", sample_max); end
    total++; if (volume_level !== 4'd0) begin bad++; $display("FAIL prime_vol got=%0d exp=0", volume_level); end
    total++; if (quiet !== 1'b0) begin bad++; $display("FAIL prime_quiet got=%0b exp=0", quiet); end
    $display("test_reset: prime window closed after %0d ticks", n + 1);
  endtask

  task automatic test_spike();
    int n;
    mic_in = 12'd2048;
    for (int i = 0; i < W - 1; i++) tick();
    mic_in = 12'd4092;
    tick();
    total++; if (max_valid !== 1'b1) begin bad++; $display("FAIL spike_valid got=%0b exp=1", max_valid); end
    total++; if (sample_max !== 10'd1023) begin bad++; $display("FAIL spike_max got=%0d exp=1023", sample_max); end
    total++; if (volume_level !== 4'd15) begin bad++; $display("FAIL spike_vol got=%0d exp=15", volume_level); end
    total++; if (wave_sample !== 10'd1023) begin bad++; $display("FAIL spike_wave got=%0d exp=1023", wave_sample); end
    mic_in = 12'd2048;
    tick();
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL pulse_width got=%0b exp=0", max_valid); end
    wait_valid(2 * W, n);
    total++; if (n !== W - 1) begin bad++; $display("FAIL spike_next_period got=%0d exp=%0d", n, W - 1); end
    total++; if (sample_max !== 10'd512) begin bad++; $display("FAIL after_spike_max got=%0d exp=512", sample_max); end
    total++; if (volume_level !== 4'd0) begin bad++; $display("FAIL after_spike_vol got=%0d exp=0", volume_level); end
    $display("test_spike: spike window and following window done");
  endtask

  task automatic test_ramp();
    int j;
    int first;
    int exp_max [3];
    int exp_vol [3];
    exp_max = '{399, 799, 999};
    exp_vol = '{0, 8, 15};
    j = 0;
    for (int w = 0; w < 3; w++) begin
      first = -1;
      for (int k = 0; k < W; k++) begin
        mic_in = 12'((j % 1000) * 4);
        j++;
        tick();
        if (max_valid === 1'b1 && first < 0) first = k;
      end
      total++; if (first !== W - 1) begin bad++; $display("FAIL ramp_period w=%0d got=%0d exp=%0d", w, first, W - 1); end
      total++; if (sample_max !== 10'(exp_max[w])) begin bad++; $display("FAIL ramp_max w=%0d got=%0d exp=%0d", w, sample_max, exp_max[w]); end
      total++; if (volume_level !== 4'(exp_vol[w])) begin bad++; $display("FAIL ramp_vol w=%0d got=%0d exp=%0d", w, volume_level, exp_vol[w]); end
      total++; if (wave_sample !== 10'((j - 1) % 1000)) begin bad++; $display("FAIL ramp_wave w=%0d got=%0d exp=%0d", w, wave_sample, (j - 1) % 1000); end
      $display("test_ramp: window %0d peak=%0d vol=%0d", w, sample_max, volume_level);
    end
  endtask

  task automatic test_volume();
    int n;
    int mics [4];
    int exp_vol [4];
    mics    = '{2176, 2172, 2052, 4000};
    exp_vol = '{1, 0, 0, 15};
    for (int v = 0; v < 4; v++) begin
      mic_in = 12'(mics[v]);
      wait_valid(2 * W, n);
      total++; if (n !== W) begin bad++; $display("FAIL vol_period v=%0d got=%0d exp=%0d", v, n, W); end
      total++; if (volume_level !== 4'(exp_vol[v])) begin bad++; $display("FAIL vol_level v=%0d got=%0d exp=%0d", v, volume_level, exp_vol[v]); end
      $display("test_volume: mic=%0d peak=%0d vol=%0d", mics[v], sample_max, volume_level);
    end
  endtask

  task automatic test_quiet();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      mic_in = 12'd400;
      for (int w = 1; w <= QW; w++) begin
        wait_valid(2 * W, n);
        total++;
        if (quiet !== (w == QW) || n !== W) begin
          bad++;
          $display("FAIL quiet_rise pass=%0d w=%0d got=%0b/%0d exp=%0b/%0d", pass, w, quiet, n, (w == QW), W);
        end
      end
      total++; if (sample_max !== 10'd100) begin bad++; $display("FAIL quiet_max got=%0d exp=100", sample_max); end
      if (pass == 0) begin
        wait_valid(2 * W, n);
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL quiet_saturate got=%0b exp=1", quiet); end
      end
      mic_in = 12'd3000;
      wait_valid(2 * W, n);
      total++; if (quiet !== 1'b0) begin bad++; $display("FAIL quiet_fall got=%0b exp=0", quiet); end
      total++; if (sample_max !== 10'd750) begin bad++; $display("FAIL loud_max got=%0d exp=750", sample_max); end
      total++; if (volume_level !== 4'd7) begin bad++; $display("FAIL loud_vol got=%0d exp=7", volume_level); end
      $display("test_quiet: pass %0d quiet rose at window %0d and fell on loud window", pass, QW);
    end
  endtask

  task automatic test_freeze();
    int n;
    logic [OUT_W-1:0] snap_max;
    logic [3:0]       snap_vol;
    logic             snap_quiet;
    logic             held_ok;
    mic_in = 12'd2048;
    for (int i = 0; i < 250; i++) tick();
    snap_max   = sample_max;
    snap_vol   = volume_level;
    snap_quiet = quiet;
    freeze = 1'b1;
    mic_in = 12'd4092;
    held_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (held_ok && (max_valid !== 1'b0 || wave_sample !== 10'd512 || sample_max !== snap_max ||
                      volume_level !== snap_vol || quiet !== snap_quiet)) begin
        held_ok = 1'b0;
        $display("FAIL freeze_hold t=%0d got=v%0b/w%0d/m%0d/l%0d/q%0b exp=v0/w512/m%0d/l%0d/q%0b",
                 i, max_valid, wave_sample, sample_max, volume_level, quiet, snap_max, snap_vol, snap_quiet);
      end
    end
    total++; if (!held_ok) bad++;
    freeze = 1'b0;
    mic_in = 12'd2048;
    wait_valid(2 * W, n);
    total++; if (n !== 150) begin bad++; $display("FAIL freeze_resume got=%0d exp=150", n); end
    total++; if (sample_max !== 10'd512) begin bad++; $display("FAIL freeze_ignored_mic got=%0d exp=512", sample_max); end
    $display("test_freeze: window closed %0d ticks after release", n);
  endtask

  task automatic test_freeze_window_end();
    int n;
    logic ok;
    mic_in = 12'd2048;
    for (int i = 0; i < W - 1; i++) tick();
    freeze = 1'b1;
    mic_in = 12'd4092;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (max_valid !== 1'b0 || sample_max !== 10'd512) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL end_freeze_hold got=v%0b/m%0d exp=v0/m512", max_valid, sample_max); end
    freeze = 1'b0;
    mic_in = 12'd2400;
    tick();
    total++; if (max_valid !== 1'b1) begin bad++; $display("FAIL deferred_valid got=%0b exp=1", max_valid); end
    total++; if (sample_max !== 10'd600) begin bad++; $display("FAIL deferred_max got=%0d exp=600", sample_max); end
    total++; if (volume_level !== 4'd2) begin bad++; $display("FAIL deferred_vol got=%0d exp=2", volume_level); end
    tick();
    wait_valid(2 * W, n);
    total++; if (n !== W - 1) begin bad++; $display("FAIL deferred_next got=%0d exp=%0d", n, W - 1); end
    $display("test_freeze_window_end: deferred peak=%0d", sample_max);
  endtask

  task automatic test_async_reset();
    int n;
    mic_in = 12'd4092;
    for (int i = 0; i < 123; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (wave_sample !== 10'd0 || sample_max !== 10'd0 || max_valid !== 1'b0 ||
        volume_level !== 4'd0 || quiet !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=w%0d/m%0d/v%0b/l%0d/q%0b exp=all0",
               wave_sample, sample_max, max_valid, volume_level, quiet);
    end
    mic_in = 12'd2048;
    @(negedge clk_sample);
    rst_n = 1'b1;
    wait_valid(2 * W, n);
    total++; if (n !== W) begin bad++; $display("FAIL reset_restart got=%0d exp=%0d", n, W); end
    total++; if (sample_max !== 10'd512) begin bad++; $display("FAIL reset_discard got=%0d exp=512", sample_max); end
    $display("test_async_reset: first window after reset took %0d ticks", n);
  endtask

  initial begin
    rst_n  = 1'b0;
    freeze = 1'b0;
    mic_in = '0;
    test_reset();
    test_spike();
    test_ramp();
    test_volume();
    test_quiet();
    test_freeze();
    test_freeze_window_end();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_peak_tracker.md
Name: mic_peak_tracker

Overview:
- Front-end audio stage feeding the waveform display. Consumes raw 12-bit microphone samples at the 20 kHz sample clock.
- Produces the display-scaled instantaneous sample (wave_sample) and the windowed peak (sample_max, max over a 5 Hz period).
- Also produces a 16-level volume index and a sustained-silence flag for the display and asystole logic.

Parameters:
- IN_W, 12, microphone sample width
- OUT_W, 10, width of wave_sample and sample_max
- WINDOW, 4000, samples per peak window (5 Hz at 20 kHz)
- QUIET_TH, 200, sample_max below this counts as a quiet window
- QUIET_WINDOWS, 50, consecutive quiet windows before quiet asserts (10 s)

Ports:
- clk_sample, input, 1, 20 kHz sample clock, one sample per rising edge
- rst_n, input, 1, asynchronous active-low reset
- freeze, input, 1, holds all state and outputs while high (driven from sw[0])
- mic_in, input, IN_W, raw unsigned mic sample, midscale 2048
- wave_sample, output, OUT_W, registered mic_in[IN_W-1:IN_W-OUT_W]
- sample_max, output, OUT_W, peak of the last completed window
- max_valid, output, 1, one-cycle pulse when sample_max updates
- volume_level, output, 4, 0..15 loudness index derived from sample_max
- quiet, output, 1, high after QUIET_WINDOWS consecutive quiet windows

Behaviour:
- Reset, async on rst_n low:
  - wave_sample=0, sample_max=0, max_valid=0, volume_level=0, quiet=0.
  - Window counter cnt=0, running max run_max=0, quiet counter qcnt=0.
  - State=PRIME.
- State machine, all transitions on the clk_sample rising edge:
  - PRIME: first window after reset; sample_max is not yet meaningful. Accumulate the window; at the window end, update the outputs and go to RUN.
  - RUN: normal operation.
  - FROZEN: entered from PRIME or RUN when freeze=1. Returns to the state it came from when freeze=0.
- FROZEN semantics:
  - cnt, run_max, qcnt, wave_sample, sample_max, volume_level and quiet all hold.
  - max_valid is 0.
  - mic_in is ignored; no partial-window data is lost or restarted.
- wave_sample: latency 1 cycle from mic_in (top OUT_W bits, truncation only).
- Window accumulation, every non-frozen cycle with s = mic_in[IN_W-1:IN_W-OUT_W]:
  - cnt < WINDOW-1: run_max <= max(run_max, s); cnt <= cnt+1.
  - cnt == WINDOW-1, the last sample of the window:
    - sample_max <= max(run_max, s); max_valid <= 1.
    - run_max <= 0; cnt <= 0.
  - The last sample is always included in the closing window, never in the next one.
  - Ties keep the value; the comparison is unsigned.
- max_valid: high exactly one cycle per completed window, every WINDOW cycles in RUN. It is also asserted for the PRIME window's end.
- volume_level, registered in the same cycle as sample_max and computed from the new peak value:
  - 0 if peak <= 512.
  - Otherwise min(15, (peak-512)>>5).
- quiet, evaluated only at the window end using the new peak:
  - peak < QUIET_TH: qcnt <= min(qcnt+1, QUIET_WINDOWS) (saturating).
  - Otherwise qcnt <= 0.
  - quiet <= (new qcnt == QUIET_WINDOWS).
  - quiet asserts in the same cycle as the QUIET_WINDOWS-th quiet max_valid. It deasserts in the cycle of the first loud window.
- Boundaries:
  - cnt width is clog2(WINDOW); wrap happens only via the explicit cnt==WINDOW-1 compare.
  - mic_in=4095 gives s=1023, so no overflow.
  - A freeze rising edge on the window-end cycle: freeze has priority. The window end is deferred, so the update occurs on the first unfrozen cycle.
  - Reset mid-window discards partial data and re-enters PRIME.

Test Plan:
- Reset release, mic_in held at 2048 (s=512) -> wave_sample=512 after 1 cycle; first max_valid at cycle 4000; sample_max=512, volume_level=0, quiet=0.
- Single spike mic_in=4092 (s=1023) on the last sample of window 2, otherwise 2048 -> window 2 sample_max=1023, volume_level=15; window 3 sample_max=512.
- Ramp s=0..999 repeating, peak 999 mid-window -> sample_max=999, volume_level=min(15,487>>5)=15; max_valid period exactly 4000 cycles.
- mic_in=400 (s=100) constant for 50 windows -> quiet rises with the 50th max_valid, not the 49th; then mic_in=3000 for one window -> quiet falls at that window's max_valid, qcnt=0.
- freeze=1 for 1000 cycles at cnt=2500 -> all outputs constant, no max_valid; after release, the next max_valid comes 1500 cycles later. freeze asserted on the cnt=3999 cycle -> the update is deferred to the first unfrozen cycle.
- rst_n pulsed low asynchronously mid-window -> all outputs 0 immediately; next max_valid exactly 4000 cycles after release.
